// File: rtl/instruction_loader_pkg.sv
// Shared pipeline definitions for the instruction loader: FSM state codes
// and the helper that sizes the largest loadable program.
package instruction_loader_pkg;

  localparam int STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_LEN_LO = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_LEN_HI = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_LOAD   = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_DONE   = 3'd4;
  localparam logic [STATE_WIDTH-1:0] ST_ERROR  = 3'd5;

  localparam int unsigned WORD_BYTES = 4;

  // Number of 32-bit words that fit in a byte-addressed memory of this width.
  function automatic int unsigned max_words(input int unsigned addr_width);
    return (32'd1 << addr_width) / WORD_BYTES;
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Receives a little-endian 16-bit word count followed by 4*count bytes from
// the UART and writes them byte by byte into instruction memory while the CPU is held.
module instruction_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_write_instruction_mem,
  output logic [31:0]           o_instruction_mem_addr,
  output logic [31:0]           o_instruction_mem_data,
  output logic                  o_cpu_halt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_byte_count
);

  import instruction_loader_pkg::*;

  localparam int          TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] MAX_WORDS    = 32'(max_words(ADDR_WIDTH));
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [STATE_WIDTH-1:0] r_state;
  logic [15:0]            r_word_count;
  logic [ADDR_WIDTH:0]    r_byte_count;
  logic [TW-1:0]          r_timeout;
  logic                   r_we;
  logic                   r_done;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [7:0]             r_data;

  logic        w_in_session;
  logic        w_start;
  logic [15:0] w_length;
  logic [31:0] w_total_bytes;
  logic        w_last_byte;

  assign w_in_session  = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) || (r_state == ST_LOAD);
  assign w_start       = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
  assign w_length      = {i_rx_data, r_word_count[7:0]};
  assign w_total_bytes = {14'd0, r_word_count, 2'b00};
  assign w_last_byte   = (32'(r_byte_count) + 32'd1) == w_total_bytes;

  // A start always wins; bytes are only consumed while a session is active,
  // and any silent cycle in a session advances the abort timer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_word_count <= '0;
      r_byte_count <= '0;
      r_timeout    <= '0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (w_start) begin
        r_state      <= ST_LEN_LO;
        r_word_count <= '0;
        r_byte_count <= '0;
        r_timeout    <= '0;
        r_addr       <= '0;
      end else if (w_in_session) begin
        if (i_rx_valid) begin
          r_timeout <= '0;
          case (r_state)
            ST_LEN_LO: begin
              r_word_count[7:0] <= i_rx_data;
              r_state           <= ST_LEN_HI;
            end
            ST_LEN_HI: begin
              r_word_count <= w_length;
              if (w_length == 16'd0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else if (32'(w_length) > MAX_WORDS) begin
                r_state <= ST_ERROR;
              end else begin
                r_state <= ST_LOAD;
              end
            end
            default: begin
              r_we         <= 1'b1;
              r_addr       <= r_byte_count[ADDR_WIDTH-1:0];
              r_data       <= i_rx_data;
              r_byte_count <= r_byte_count + 1'b1;
              if (w_last_byte) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          endcase
        end else if (r_timeout == TIMEOUT_LAST) begin
          r_state <= ST_ERROR;
        end else begin
          r_timeout <= r_timeout + 1'b1;
        end
      end
    end
  end

  assign o_write_instruction_mem = r_we;
  assign o_instruction_mem_addr  = 32'(r_addr);
  assign o_instruction_mem_data  = {24'd0, r_data};
  assign o_cpu_halt              = (r_state != ST_DONE);
  assign o_busy                  = w_in_session;
  assign o_done                  = r_done;
  assign o_error                 = (r_state == ST_ERROR);
  assign o_byte_count            = r_byte_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader (ADDR_WIDTH 12, TIMEOUT_CYCLES 16).
module tb_instruction_loader;

  localparam int ADDR_WIDTH = 12;
  localparam int TIMEOUT    = 16;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_start = 1'b0;
  logic [7:0]          i_rx_data = 8'd0;
  logic                i_rx_valid = 1'b0;
  logic                o_write_instruction_mem;
  logic [31:0]         o_instruction_mem_addr;
  logic [31:0]         o_instruction_mem_data;
  logic                o_cpu_halt;
  logic                o_busy;
  logic                o_done;
  logic                o_error;
  logic [ADDR_WIDTH:0] o_byte_count;

  int checks = 0;
  int failures = 0;
  int doneCount = 0;
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  instruction_loader #(.ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_write_instruction_mem(o_write_instruction_mem),
    .o_instruction_mem_addr(o_instruction_mem_addr),
    .o_instruction_mem_data(o_instruction_mem_data),
    .o_cpu_halt(o_cpu_halt),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error),
    .o_byte_count(o_byte_count)
  );

  always #5 i_clk = ~i_clk;

  // Log every write strobe and done pulse, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_write_instruction_mem) begin
      wrAddr.push_back(o_instruction_mem_addr);
      wrData.push_back(o_instruction_mem_data);
    end
    if (o_done) doneCount++;
  end

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    doneCount = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
    checks++;
    if ({o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data} !== 65'd0) begin
      failures++;
      $display("[TB] FAIL reset_write: got we=%0b addr=%0h data=%0h expected 0/0/0",
               o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data);
    end
    checks++;
    if ({o_cpu_halt, o_busy, o_done, o_error} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_status: got halt/busy/done/err=%b expected 1000",
               {o_cpu_halt, o_busy, o_done, o_error});
    end
    checks++;
    if (o_byte_count !== 13'd0) begin
      failures++;
      $display("[TB] FAIL reset_count: got %0d expected 0", o_byte_count);
    end
  endtask

  task automatic test_load();
    logic [7:0] bytes[8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    clearLog();
    pulseStart();
    checks++;
    if ({o_busy, o_cpu_halt} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL load_busy: got busy/halt=%b expected 11", {o_busy, o_cpu_halt});
    end
    sendByte(8'h02);
    sendByte(8'h00);
    for (int i = 0; i < 8; i++) begin
      sendByte(bytes[i]);
      if (i == 0) begin
        checks++;
        if ({o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data} !== {1'b1, 32'd0, 32'h000000AA}) begin
          failures++;
          $display("[TB] FAIL load_first_write: got we=%0b addr=%0h data=%0h expected 1/0/aa",
                   o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data);
        end
      end
    end
    checks++;
    if ({o_done, o_cpu_halt, o_write_instruction_mem} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL load_done_with_last: got done/halt/we=%b expected 101",
               {o_done, o_cpu_halt, o_write_instruction_mem});
    end
    idle(3);
    checks++;
    if (wrAddr.size() != 8) begin
      failures++;
      $display("[TB] FAIL load_write_count: got %0d expected 8", wrAddr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wrAddr[i] !== 32'(i) || wrData[i] !== {24'd0, bytes[i]}) begin
          failures++;
          $display("[TB] FAIL load_write_%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   i, wrAddr[i], wrData[i], i, bytes[i]);
        end
      end
    end
    checks++;
    if (doneCount != 1 || o_cpu_halt !== 1'b0 || o_byte_count !== 13'd8 || o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_final: got done_pulses=%0d halt=%0b count=%0d busy=%0b expected 1/0/8/0",
               doneCount, o_cpu_halt, o_byte_count, o_busy);
    end
  endtask

  task automatic test_zero_length();
    clearLog();
    pulseStart();
    sendByte(8'h00);
    sendByte(8'h00);
    idle(2);
    checks++;
    if (wrAddr.size() != 0 || doneCount != 1 || o_byte_count !== 13'd0 || o_cpu_halt !== 1'b0 || o_error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_length: got writes=%0d done=%0d count=%0d halt=%0b err=%0b expected 0/1/0/0/0",
               wrAddr.size(), doneCount, o_byte_count, o_cpu_halt, o_error);
    end
  endtask

  task automatic test_oversize();
    clearLog();
    pulseStart();
    sendByte(8'h01);
    sendByte(8'h04);
    idle(3);
    checks++;
    if (o_error !== 1'b1 || o_cpu_halt !== 1'b1 || o_busy !== 1'b0 || wrAddr.size() != 0 || doneCount != 0) begin
      failures++;
      $display("[TB] FAIL oversize: got err=%0b halt=%0b busy=%0b writes=%0d done=%0d expected 1/1/0/0/0",
               o_error, o_cpu_halt, o_busy, wrAddr.size(), doneCount);
    end
  endtask

  task automatic test_timeout();
    clearLog();
    pulseStart();
    checks++;
    if (o_error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_start_clears_error: got %0b expected 0", o_error);
    end
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'hAA);
    idle(TIMEOUT - 1);
    checks++;
    if (o_error !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_early: got err=%0b busy=%0b expected 0/1", o_error, o_busy);
    end
    idle(1);
    checks++;
    if (o_error !== 1'b1 || wrAddr.size() != 1 || o_byte_count !== 13'd1) begin
      failures++;
      $display("[TB] FAIL timeout_abort: got err=%0b writes=%0d count=%0d expected 1/1/1",
               o_error, wrAddr.size(), o_byte_count);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] bytes[4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    clearLog();
    pulseStart();
    sendByte(8'h02);
    sendByte(8'h00);
    sendByte(8'hE1);
    sendByte(8'hE2);
    sendByte(8'hE3);
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    checks++;
    if (o_write_instruction_mem !== 1'b0 || o_busy !== 1'b0 || o_byte_count !== 13'd0 || o_cpu_halt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_load: got we=%0b busy=%0b count=%0d halt=%0b expected 0/0/0/1",
               o_write_instruction_mem, o_busy, o_byte_count, o_cpu_halt);
    end
    clearLog();
    pulseStart();
    sendByte(8'h01);
    sendByte(8'h00);
    for (int i = 0; i < 4; i++) sendByte(bytes[i]);
    idle(2);
    checks++;
    if (wrAddr.size() != 4 || doneCount != 1) begin
      failures++;
      $display("[TB] FAIL reload_count: got writes=%0d done=%0d expected 4/1", wrAddr.size(), doneCount);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wrAddr[i] !== 32'(i) || wrData[i] !== {24'd0, bytes[i]}) begin
          failures++;
          $display("[TB] FAIL reload_write_%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   i, wrAddr[i], wrData[i], i, bytes[i]);
        end
      end
    end
  endtask

  task automatic test_discard();
    logic [7:0] bytes[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    clearLog();
    sendByte(8'h77);
    checks++;
    if (o_cpu_halt !== 1'b0 || o_byte_count !== 13'd4 || wrAddr.size() != 0) begin
      failures++;
      $display("[TB] FAIL discard_in_done: got halt=%0b count=%0d writes=%0d expected 0/4/0",
               o_cpu_halt, o_byte_count, wrAddr.size());
    end
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    sendByte(8'h99);
    checks++;
    if (o_busy !== 1'b0 || o_cpu_halt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL discard_in_idle: got busy=%0b halt=%0b expected 0/1", o_busy, o_cpu_halt);
    end
    @(negedge i_clk);
    i_start    = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h05;
    @(negedge i_clk);
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    sendByte(8'h01);
    sendByte(8'h00);
    for (int i = 0; i < 4; i++) sendByte(bytes[i]);
    idle(2);
    checks++;
    if (wrAddr.size() != 4 || doneCount != 1 || o_cpu_halt !== 1'b0 || o_byte_count !== 13'd4) begin
      failures++;
      $display("[TB] FAIL discard_with_start: got writes=%0d done=%0d halt=%0b count=%0d expected 4/1/0/4",
               wrAddr.size(), doneCount, o_cpu_halt, o_byte_count);
    end else begin
      checks++;
      if (wrAddr[3] !== 32'd3 || wrData[3] !== 32'h40 || wrData[0] !== 32'h10) begin
        failures++;
        $display("[TB] FAIL discard_data: got addr3=%0h data3=%0h data0=%0h expected 3/40/10",
                 wrAddr[3], wrData[3], wrData[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_zero_length();
    test_oversize();
    test_timeout();
    test_reset_mid_load();
    test_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, instruction memory byte-address width (4 KiB).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle cycles between received bytes before abort.
REQ-003 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_start  input  1  begin a new load session.
REQ-006 SHALL have port i_rx_data  input  8  byte from UART receiver.
REQ-007 SHALL have port i_rx_valid  input  1  one-cycle strobe; i_rx_data valid.
REQ-008 SHALL have port o_write_instruction_mem  output  1  byte write strobe to fetch stage memory.
REQ-009 SHALL have port o_instruction_mem_addr  output  32  byte address, zero-extended from ADDR_WIDTH.
REQ-010 SHALL have port o_instruction_mem_data  output  32  {24'b0, byte}.
REQ-011 SHALL have port o_cpu_halt  output  1  holds the pipeline (drives fetch i_halt).
REQ-012 SHALL have port o_busy  output  1  high in LEN_LO, LEN_HI, LOAD.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port o_error  output  1  level; high while in ERROR.
REQ-015 SHALL have port o_byte_count  output  ADDR_WIDTH+1  bytes written in the current session.

Function
REQ-016 SHALL implement states IDLE, LEN_LO, LEN_HI, LOAD, DONE, ERROR.
REQ-017 SHALL, on i_start in IDLE, DONE or ERROR, go to LEN_LO and clear byte counter, address, and timeout counter; i_start in other states is ignored.
REQ-018 SHALL, in LEN_LO, capture an accepted byte as word-count[7:0] and go to LEN_HI; in LEN_HI, capture it as word-count[15:8].
REQ-019 SHALL, from LEN_HI, go to DONE if word-count = 0 (no writes), to ERROR if word-count > 2^ADDR_WIDTH/4, else to LOAD.
REQ-020 SHALL, in LOAD, write the k-th accepted byte (k from 0) to address k: strobe, address and data registered, asserted together one cycle after i_rx_valid, for exactly one cycle.
REQ-021 SHALL go to DONE in the cycle the write of byte 4*word-count-1 is issued; o_done pulses in that same cycle.
REQ-022 SHALL count idle cycles in LEN_LO, LEN_HI, LOAD, clear the count on each accepted byte, and go to ERROR when the count reaches TIMEOUT_CYCLES.
REQ-023 SHALL ignore i_rx_valid in IDLE, DONE, ERROR; i_start and i_rx_valid in the same cycle -> start taken, byte discarded.
REQ-024 SHALL drive o_cpu_halt high in every state except DONE.
REQ-025 SHALL keep o_byte_count at its final value in DONE and ERROR until the next i_start.
REQ-026 SHALL never let the address wrap; the byte counter is wide enough for 2^ADDR_WIDTH.

Reset
REQ-027 SHALL, on i_reset, enter IDLE within one cycle, even mid-load.
REQ-028 SHALL reset outputs to: o_write_instruction_mem 0, addr 0, data 0, o_cpu_halt 1, o_busy 0, o_done 0, o_error 0, o_byte_count 0.

Structure
REQ-029 SHALL take the state encoding and the max-word constant from the shared pipeline package.
REQ-030 SHALL be a single module; the timeout counter may be an inline counter (no sub-module required).

Verification
REQ-031 SHALL cover: start, bytes 02,00,AA,BB,CC,DD,11,22,33,44 -> writes addr 0..7 with AA..44, o_done at the 8th write, o_cpu_halt low afterwards, o_byte_count 8.
REQ-032 SHALL cover: start, bytes 00,00 -> DONE with no write strobe, o_byte_count 0.
REQ-033 SHALL cover: start, bytes 01,04 (1025 words) -> ERROR, o_error 1, o_cpu_halt 1, no writes.
REQ-034 SHALL cover: TIMEOUT_CYCLES=16, start, bytes 01,00,AA, then silence -> ERROR 16 cycles after the AA byte, one write only.
REQ-035 SHALL cover: i_reset asserted after 3 of 8 load bytes -> IDLE next cycle, strobe low, count 0; new session re-writes from addr 0.
REQ-036 SHALL cover: i_start with i_rx_valid in the same cycle, and i_rx_valid in IDLE -> bytes discarded, length taken from the next byte.
